dmem_port_arbiter: RTL and testbench

Single-port memory arbiter that shares one data-memory bus between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write). It sits between the pipeline's fetch and memory-access stages and the memory subsystem. It accepts one request at a time, drives it onto the memory bus with a valid/ready handshake, and routes the response back to the owner. Requesters use the accept/response signals as their stall condition.

---
 rtl/dmem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Single-outstanding arbiter sharing one data-memory bus between IFU (read) and LSU (read/write).
// Optional IFU starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_req_ready,
  output logic                ifu_resp_valid,
  input  logic                lsu_req_valid,
  input  logic                lsu_req_wen,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_req_ready,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e              state_q, state_d;
  logic                owner_lsu_q, owner_lsu_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                grant_lsu, grant_ifu;
  logic                force_ifu;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  // Counts back-to-back LSU wins over a waiting IFU; at 3 the IFU gets the next contended slot.
  logic [1:0] starve_q, starve_d;

  assign force_ifu = (starve_q == 2'd3);

  always_comb begin
    starve_d = starve_q;
    if (grant_ifu)
      starve_d = 2'd0;
    else if (grant_lsu)
      starve_d = ifu_req_valid ? starve_q + 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= 2'd0;
    else     starve_q <= starve_d;
  end
`else
  assign force_ifu = 1'b0;
`endif

  always_comb begin
    grant_lsu = (state_q == IDLE) && lsu_req_valid && !(force_ifu && ifu_req_valid);
    grant_ifu = (state_q == IDLE) && ifu_req_valid && !grant_lsu;
  end

  always_comb begin
    state_d     = state_q;
    owner_lsu_d = owner_lsu_q;
    wen_d       = wen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    unique case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          state_d     = REQ;
          owner_lsu_d = 1'b1;
          wen_d       = lsu_req_wen;
          addr_d      = lsu_req_addr;
          wdata_d     = lsu_req_wdata;
          // Loads never carry byte enables onto the bus.
          wstrb_d     = lsu_req_wen ? lsu_req_wstrb : '0;
        end else if (grant_ifu) begin
          state_d     = REQ;
          owner_lsu_d = 1'b0;
          wen_d       = 1'b0;
          addr_d      = ifu_req_addr;
          wdata_d     = '0;
          wstrb_d     = '0;
        end
      end
      REQ:     if (mem_req_ready)  state_d = RESP;
      RESP:    if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_lsu_q <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_lsu_q <= owner_lsu_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

  // Responses are combinational from the memory and only honoured while waiting for one.
  always_comb begin
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    resp_rdata     = '0;
    if (state_q == RESP && mem_resp_valid) begin
      ifu_resp_valid = !owner_lsu_q;
      lsu_resp_valid = owner_lsu_q;
      resp_rdata     = mem_resp_rdata;
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: transaction-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
    .ifu_req_ready(ifu_req_ready), .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transaction model: one outstanding transfer, "issued" once memory took the request.
  bit          m_busy = 0, m_issued = 0, m_own_lsu = 0, m_wen = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  int          m_run = 0;

  function automatic bit pick_lsu();
    return lsu_req_valid && !(GUARD && ifu_req_valid && m_run >= 3);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_issued = 0; m_run = 0;
    end else if (!m_busy) begin
      if (pick_lsu()) begin
        m_busy = 1; m_own_lsu = 1; m_wen = lsu_req_wen; m_addr = lsu_req_addr;
        m_wdata = lsu_req_wdata; m_wstrb = lsu_req_wen ? lsu_req_wstrb : 4'h0;
        m_run = ifu_req_valid ? m_run + 1 : 0;
      end else if (ifu_req_valid) begin
        m_busy = 1; m_own_lsu = 0; m_wen = 0; m_addr = ifu_req_addr; m_wstrb = 4'h0;
        m_run = 0;
      end
    end else if (!m_issued) begin
      if (mem_req_ready) m_issued = 1;
    end else if (mem_resp_valid) begin
      m_busy = 0; m_issued = 0;
    end
  end

  bit   cmp_en = 0;
  byte  grant_log[$];
  int   lsu_resp_cnt = 0;
  bit   e_lrdy, e_irdy, e_lresp, e_iresp;
  logic [31:0] e_rdata;

  always @(negedge clk) begin
    if (cmp_en) begin
      e_lrdy  = !m_busy && pick_lsu();
      e_irdy  = !m_busy && ifu_req_valid && !e_lrdy;
      e_lresp = m_busy && m_issued && mem_resp_valid && m_own_lsu;
      e_iresp = m_busy && m_issued && mem_resp_valid && !m_own_lsu;
      e_rdata = (e_lresp || e_iresp) ? mem_resp_rdata : 32'h0;
      chk("m_lsu_req_ready", lsu_req_ready, e_lrdy);
      chk("m_ifu_req_ready", ifu_req_ready, e_irdy);
      chk("m_lsu_resp_valid", lsu_resp_valid, e_lresp);
      chk("m_ifu_resp_valid", ifu_resp_valid, e_iresp);
      chk("m_resp_rdata", resp_rdata, e_rdata);
      chk("m_mem_req_valid", mem_req_valid, m_busy && !m_issued);
      if (m_busy && !m_issued) begin
        chk("m_mem_req_wen", mem_req_wen, m_wen);
        chk("m_mem_req_addr", mem_req_addr, m_addr);
        chk("m_mem_req_wstrb", mem_req_wstrb, m_wstrb);
        if (m_own_lsu) chk("m_mem_req_wdata", mem_req_wdata, m_wdata);
      end
      if (!rst && lsu_req_ready) grant_log.push_back("L");
      if (!rst && ifu_req_ready) grant_log.push_back("I");
      if (lsu_resp_valid) lsu_resp_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string exp_order;
    rst = 1; ifu_req_valid = 0; ifu_req_addr = '0; lsu_req_valid = 0; lsu_req_wen = 0;
    lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wstrb = '0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_rdata = '0;
    tick(); cmp_en = 1;
    smp();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_readies", {ifu_req_ready, lsu_req_ready}, 0);
    chk("rst_resp_valids", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_payload", {mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb}, 0);
    tick(); rst = 0;

    // IFU-only read, immediate memory
    tick(); ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    smp(); chk("t1_accept_N", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; ifu_req_addr = '0; mem_req_ready = 1;
    smp(); chk("t1_memvalid_N1", mem_req_valid, 1); chk("t1_addr", mem_req_addr, 32'h8000_0000);
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    smp(); chk("t1_resp_N2", ifu_resp_valid, 1); chk("t1_rdata", resp_rdata, 32'h413);
    chk("t1_lsu_resp", lsu_resp_valid, 0);
    tick(); mem_resp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    smp(); chk("t1_reaccept_N3", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0013;
    tick(); mem_resp_valid = 0;

    // LSU store with two memory wait cycles
    tick(); lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_1004;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'h3;
    smp(); chk("t2_accept", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
    for (int i = 0; i < 2; i++) begin
      smp(); chk("t2_wait_payload",
                 {mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb},
                 {1'b1, 1'b1, 32'h8000_1004, 32'hDEAD_BEEF, 4'h3});
      tick();
    end
    mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0;
    smp(); chk("t2_ack", {lsu_resp_valid, ifu_resp_valid}, 2'b10);
    tick(); mem_resp_valid = 0;

    // Simultaneous IFU and LSU (load with stray strobes)
    tick(); ifu_req_valid = 1; ifu_req_addr = 32'h8000_0040;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_2000; lsu_req_wstrb = 4'hF;
    smp(); chk("t3_lsu_first", {lsu_req_ready, ifu_req_ready}, 2'b10);
    tick(); lsu_req_valid = 0; lsu_req_wstrb = 0; mem_req_ready = 1;
    smp(); chk("t3_no_ready_req", ifu_req_ready, 0); chk("t3_load_wstrb", mem_req_wstrb, 0);
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_0001;
    smp(); chk("t3_load_resp", lsu_resp_valid, 1);
    tick(); mem_resp_valid = 0;
    smp(); chk("t3_ifu_next", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    smp(); chk("t3_ifu_payload", {mem_req_wen, mem_req_addr, mem_req_wstrb}, {1'b0, 32'h8000_0040, 4'h0});
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0093;
    tick(); mem_resp_valid = 0;

    // LSU load, response 5 cycles after handshake; IFU waits meanwhile
    lsu_resp_cnt = 0;
    tick(); lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_3000;
    smp(); chk("t4_accept", lsu_req_ready, 1);
    tick(); lsu_req_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h0000_0100; mem_req_ready = 1;
    smp(); chk("t4_ready_hs", {lsu_req_ready, ifu_req_ready}, 0);
    tick(); mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      smp(); chk("t4_ready_wait", {lsu_req_ready, ifu_req_ready}, 0);
      tick();
    end
    mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    smp(); chk("t4_resp", {lsu_resp_valid, resp_rdata}, {1'b1, 32'h1234_5678});
    chk("t4_ready_resp", {lsu_req_ready, ifu_req_ready}, 0);
    tick(); mem_resp_valid = 0;
    smp(); chk("t4_resp_once", lsu_resp_cnt, 1); chk("t4_ifu_after", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0513;
    tick(); mem_resp_valid = 0;

    // Reset while in RESP, then a stale memory response
    tick(); lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_4000;
    lsu_req_wdata = 32'h0BAD_F00D; lsu_req_wstrb = 4'hF;
    tick(); lsu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0;
    tick(); rst = 1;
    tick(); rst = 0;
    smp(); chk("t5_idle_after_rst", mem_req_valid, 0);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0;
    smp(); chk("t5_stale_ignored", {lsu_resp_valid, ifu_resp_valid, resp_rdata}, 0);
    tick(); mem_resp_valid = 0; ifu_req_valid = 1; ifu_req_addr = 32'h8000_0080;
    smp(); chk("t5_next_accept", ifu_req_ready, 1);
    tick(); ifu_req_valid = 0; mem_req_ready = 1;
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0737;
    smp(); chk("t5_next_resp", {ifu_resp_valid, resp_rdata}, {1'b1, 32'h0000_0737});
    tick(); mem_resp_valid = 0;

    // Continuous contention
    tick(); rst = 1;
    tick(); rst = 0; grant_log.delete();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100; lsu_req_valid = 1; lsu_req_wen = 0;
    lsu_req_addr = 32'h8000_5000; mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 32'h55;
    repeat (26) tick();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    exp_order = GUARD ? "LLLILLLI" : "LLLLLLLL";
    chk("t6_grant_count_ge8", grant_log.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) chk($sformatf("t6_grant%0d", i), grant_log[i], exp_order[i]);
    end
    repeat (3) tick();

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
